// File: rtl/uart_tx_framer.sv
// uart_tx_framer
// Transmit framer: accepts one DATA_W-bit word over a valid/ready handshake
// and serialises it onto tx in this order: start bit, data bits LSB first,
// an optional parity bit, then one or two stop bits. The external baud_tick
// paces every bit.
// All outputs are registered. They are computed from the next-state values,
// so tx changes on the same clock edge that consumes a baud tick.
module uart_tx_framer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              baud_tick,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              parity_en,
    input  logic              parity_type,
    input  logic              stop2,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    // The bit counter only has to reach DATA_W-1, so it never wraps inside a frame.
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_n;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  bit_cnt_n;
    logic              parity_bit;
    logic              parity_n;
    logic              par_en_q;
    logic              par_en_n;
    logic              stop2_q;
    logic              stop2_n;
    logic              stop_cnt;
    logic              stop_cnt_n;
    logic              tx_n;
    logic              busy_n;
    logic              in_ready_n;
    logic              done_n;
    logic              accept;

    // in_ready is registered and is high only in IDLE, so an accept always
    // starts a frame from IDLE.
    assign accept = in_valid & in_ready;

    // Next-state logic. The configuration is captured at accept, so later
    // changes on the config pins do not affect the frame in flight.
    always_comb begin
        state_n    = state;
        shift_n    = shift_reg;
        bit_cnt_n  = bit_cnt;
        parity_n   = parity_bit;
        par_en_n   = par_en_q;
        stop2_n    = stop2_q;
        stop_cnt_n = stop_cnt;
        done_n     = 1'b0;

        case (state)
            ST_IDLE: begin
                // Any baud tick seen here, including one in the accept cycle, is ignored.
                if (accept) begin
                    shift_n   = in_data;
                    par_en_n  = parity_en;
                    stop2_n   = stop2;
                    parity_n  = (^in_data) ^ parity_type;
                    bit_cnt_n = '0;
                    state_n   = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (baud_tick) begin
                    state_n = ST_START;
                end
            end

            ST_START: begin
                if (baud_tick) begin
                    bit_cnt_n = '0;
                    state_n   = ST_DATA;
                end
            end

            ST_DATA: begin
                if (baud_tick) begin
                    shift_n = shift_reg >> 1;
                    if (bit_cnt == LAST_BIT) begin
                        stop_cnt_n = 1'b0;
                        state_n    = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end

            ST_PARITY: begin
                if (baud_tick) begin
                    stop_cnt_n = 1'b0;
                    state_n    = ST_STOP;
                end
            end

            ST_STOP: begin
                // The second stop bit is sent only when two stop bits were latched.
                if (baud_tick) begin
                    if (stop_cnt == stop2_q) begin
                        done_n  = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        stop_cnt_n = 1'b1;
                    end
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Output decode from next-state values; the results are registered below.
    always_comb begin
        tx_n       = 1'b1;
        busy_n     = (state_n != ST_IDLE);
        in_ready_n = (state_n == ST_IDLE);
        case (state_n)
            ST_START:  tx_n = 1'b0;
            ST_DATA:   tx_n = shift_n[0];
            ST_PARITY: tx_n = parity_n;
            default:   tx_n = 1'b1;
        endcase
    end

    // State and output registers. Reset abandons any partial frame and idles the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            parity_bit <= 1'b0;
            par_en_q   <= 1'b0;
            stop2_q    <= 1'b0;
            stop_cnt   <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            in_ready   <= 1'b1;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            shift_reg  <= shift_n;
            bit_cnt    <= bit_cnt_n;
            parity_bit <= parity_n;
            par_en_q   <= par_en_n;
            stop2_q    <= stop2_n;
            stop_cnt   <= stop_cnt_n;
            tx         <= tx_n;
            busy       <= busy_n;
            in_ready   <= in_ready_n;
            done       <= done_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer
// Directed and randomised frames for two framers, DATA_W=8 and DATA_W=5.
// The expected bit sequence of each frame is built from the framing rules:
// a start bit, data bits LSB first, a parity bit chosen so that the count of
// ones comes out even or odd, and the stop bits. tx is then compared over
// every cycle of every bit period.
module tb_uart_tx_framer;

    localparam int BAUD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       baud_tick;
    logic [7:0] in_data;
    logic       in_valid;
    logic       parity_en;
    logic       parity_type;
    logic       stop2;
    logic       sel;

    logic in_valid8, in_ready8, tx8, busy8, done8;
    logic in_valid5, in_ready5, tx5, busy5, done5;
    logic in_ready_o, tx_o, busy_o, done_o;

    int vectors     = 0;
    int miscompares = 0;
    int phase       = 0;

    assign in_valid8  = in_valid & ~sel;
    assign in_valid5  = in_valid & sel;
    assign in_ready_o = sel ? in_ready5 : in_ready8;
    assign tx_o       = sel ? tx5 : tx8;
    assign busy_o     = sel ? busy5 : busy8;
    assign done_o     = sel ? done5 : done8;

    uart_tx_framer #(.DATA_W(8)) dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .baud_tick   (baud_tick),
        .in_data     (in_data),
        .in_valid    (in_valid8),
        .in_ready    (in_ready8),
        .parity_en   (parity_en),
        .parity_type (parity_type),
        .stop2       (stop2),
        .tx          (tx8),
        .busy        (busy8),
        .done        (done8)
    );

    uart_tx_framer #(.DATA_W(5)) dut5 (
        .clk         (clk),
        .rst_n       (rst_n),
        .baud_tick   (baud_tick),
        .in_data     (in_data[4:0]),
        .in_valid    (in_valid5),
        .in_ready    (in_ready5),
        .parity_en   (parity_en),
        .parity_type (parity_type),
        .stop2       (stop2),
        .tx          (tx5),
        .busy        (busy5),
        .done        (done5)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advances one clock. Outputs are sampled 1 time unit after the edge; the
    // baud tick for the following edge is driven at the same moment.
    task automatic step();
        @(posedge clk);
        #1;
        phase     = (phase + 1) % BAUD;
        baud_tick = (phase == BAUD - 1);
    endtask

    // Presents a word and waits for it to be accepted. With align set, the
    // accept is placed on an edge that also carries a baud tick.
    task automatic applyStimulus(input int data, input bit pe, input bit pt, input bit s2,
                                 input bit align, input bit hold, output int waited);
        bit prev_ready;
        int guard;
        in_data     = 8'(data);
        parity_en   = pe;
        parity_type = pt;
        stop2       = s2;
        if (align) begin
            guard = 0;
            while (!baud_tick && guard < 2 * BAUD) begin
                step();
                guard++;
            end
        end
        in_valid = 1'b1;
        waited   = 0;
        forever begin
            prev_ready = in_ready_o;
            step();
            if (prev_ready) break;
            waited++;
            if (waited > 200) begin
                checkOutput("accept_timeout", 32'(waited), 32'd0);
                break;
            end
        end
        checkOutput("busy_after_accept", busy_o, 1);
        checkOutput("ready_after_accept", in_ready_o, 0);
        if (!hold) in_valid = 1'b0;
    endtask

    // Builds the reference frame and follows tx tick by tick until done.
    task automatic checkFrame(input int w, input int data, input bit pe, input bit pt,
                              input bit s2, input string name);
        bit exp_q[$];
        int ones;
        bit prev;
        int guard;
        ones = 0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < w; i++) begin
            exp_q.push_back(((data >> i) & 1) != 0);
            ones += (data >> i) & 1;
        end
        if (pe) exp_q.push_back(((ones % 2) != 0) ^ pt);
        exp_q.push_back(1'b1);
        if (s2) exp_q.push_back(1'b1);

        // Disturb the config pins after accept; the frame must keep the latched values.
        parity_en   = 1'($urandom);
        parity_type = ~pt;
        stop2       = ~s2;

        guard = 0;
        forever begin
            prev = baud_tick;
            step();
            if (prev) break;
            checkOutput({name, "_wait_tx"}, tx_o, 1);
            checkOutput({name, "_wait_done"}, done_o, 0);
            guard++;
            if (guard > 4 * BAUD) begin
                checkOutput({name, "_tick_timeout"}, 32'(guard), 32'd0);
                break;
            end
        end

        foreach (exp_q[i]) begin
            checkOutput($sformatf("%s_bit%0d", name, i), tx_o, exp_q[i]);
            checkOutput($sformatf("%s_busy%0d", name, i), busy_o, 1);
            checkOutput($sformatf("%s_done%0d", name, i), done_o, 0);
            guard = 0;
            forever begin
                prev = baud_tick;
                step();
                if (prev) break;
                checkOutput($sformatf("%s_hold%0d", name, i), tx_o, exp_q[i]);
                guard++;
                if (guard > 4 * BAUD) begin
                    checkOutput({name, "_bit_timeout"}, 32'(guard), 32'd0);
                    break;
                end
            end
        end

        checkOutput({name, "_done"}, done_o, 1);
        checkOutput({name, "_end_busy"}, busy_o, 0);
        checkOutput({name, "_end_ready"}, in_ready_o, 1);
        checkOutput({name, "_end_tx"}, tx_o, 1);
    endtask

    // Directed sequence followed by randomised frames on both widths.
    initial begin
        int waited;
        int ticks;
        int guard;
        int w;
        int data;
        bit pe, pt, s2, al;
        bit prev;

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        baud_tick   = 1'b0;
        parity_en   = 1'b0;
        parity_type = 1'b0;
        stop2       = 1'b0;
        sel         = 1'b0;

        step();
        step();
        checkOutput("rst_tx8", tx8, 1);
        checkOutput("rst_busy8", busy8, 0);
        checkOutput("rst_ready8", in_ready8, 1);
        checkOutput("rst_done8", done8, 0);
        checkOutput("rst_tx5", tx5, 1);
        checkOutput("rst_ready5", in_ready5, 1);
        rst_n = 1'b1;
        step();
        step();

        applyStimulus(32'hA5, 1, 0, 0, 0, 0, waited);
        checkFrame(8, 32'hA5, 1, 0, 0, "a5_even");
        step();
        applyStimulus(32'hA5, 1, 1, 0, 0, 0, waited);
        checkFrame(8, 32'hA5, 1, 1, 0, "a5_odd");
        step();
        applyStimulus(32'hA5, 0, 0, 1, 0, 0, waited);
        checkFrame(8, 32'hA5, 0, 0, 1, "a5_nopar_stop2");
        step();

        // Back-to-back: in_valid stays high, so the second word goes in during the done cycle.
        applyStimulus(32'h00, 1, 0, 0, 0, 1, waited);
        checkFrame(8, 32'h00, 1, 0, 0, "b2b_00");
        applyStimulus(32'hFF, 1, 0, 0, 0, 0, waited);
        checkOutput("b2b_accept_wait", 32'(waited), 32'd0);
        checkFrame(8, 32'hFF, 1, 0, 0, "b2b_ff");
        step();

        applyStimulus(32'h6B, 1, 1, 1, 1, 0, waited);
        checkFrame(8, 32'h6B, 1, 1, 1, "coincident");
        step();

        // Asynchronous reset in the middle of data bit 3 of 0x47, whose bit 3 is 0.
        applyStimulus(32'h47, 1, 0, 0, 0, 0, waited);
        ticks = 0;
        guard = 0;
        while (ticks < 5 && guard < 10 * BAUD) begin
            prev = baud_tick;
            step();
            if (prev) ticks++;
            guard++;
        end
        checkOutput("pre_reset_ticks", 32'(ticks), 32'd5);
        checkOutput("pre_reset_tx", tx_o, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_tx", tx_o, 1);
        checkOutput("mid_rst_busy", busy_o, 0);
        checkOutput("mid_rst_ready", in_ready_o, 1);
        checkOutput("mid_rst_done", done_o, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        checkOutput("post_rst_tx", tx_o, 1);
        checkOutput("post_rst_busy", busy_o, 0);
        applyStimulus(32'h3C, 1, 0, 0, 0, 0, waited);
        checkFrame(8, 32'h3C, 1, 0, 0, "after_rst_3c");
        step();

        // Five-bit framer.
        sel = 1'b1;
        step();
        applyStimulus(32'h15, 1, 1, 0, 0, 0, waited);
        checkFrame(5, 32'h15, 1, 1, 0, "w5_15_odd");
        step();

        for (int n = 0; n < 16; n++) begin
            sel  = (n >= 12);
            w    = sel ? 5 : 8;
            data = int'($urandom_range(0, (1 << w) - 1));
            pe   = 1'($urandom);
            pt   = 1'($urandom);
            s2   = 1'($urandom);
            al   = 1'($urandom);
            step();
            applyStimulus(data, pe, pt, s2, al, 0, waited);
            checkFrame(w, data, pe, pt, s2, $sformatf("rnd%0d", n));
        end

        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
